// File: rtl/cpu_cycle_pkg.sv
// rtl/cpu_cycle_pkg.sv - state encoding and mode constants for the CPU run controller
package cpu_cycle_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_IDLE,
    ST_RUN,
    ST_STEP
  } state_t;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_STEP  = 2'b11;

endpackage

// File: rtl/cpu_cycle_ctrl_if.sv
// rtl/cpu_cycle_ctrl_if.sv - control/status bundle between a run master and the cycle controller
interface cpu_cycle_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
);
  logic [1:0]       mode;
  logic             start;
  logic             step;
  logic             halt_req;
  logic [CNT_W-1:0] run_len;
  logic [DIV_W-1:0] div;
  logic             cpu_rst_n;
  logic             cpu_en;
  logic [CNT_W-1:0] cycles;
  logic             busy;
  logic             done;

  modport master (
    output mode, start, step, halt_req, run_len, div,
    input  cpu_rst_n, cpu_en, cycles, busy, done
  );

  modport slave (
    input  mode, start, step, halt_req, run_len, div,
    output cpu_rst_n, cpu_en, cycles, busy, done
  );
endinterface

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - wrapping prescaler, tick on the cycle the count equals div
module clk_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = en && !clr && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/cpu_cycle_ctrl.sv
// rtl/cpu_cycle_ctrl.sv - CPU run controller: reset hold, free/count/step runs, retired-cycle counter
module cpu_cycle_ctrl
  import cpu_cycle_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DIV_W    = 8,
  parameter int RST_HOLD = 4
) (
  input logic              sysclk,
  input logic              sysrst_n,
  cpu_cycle_ctrl_if.slave  bus
);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t           state;
  logic [HOLD_W-1:0] hold_cnt;
  logic             count_mode;
  logic [CNT_W-1:0] run_len_q;
  logic [DIV_W-1:0] div_q;
  logic             cpu_rst_q;
  logic             cpu_en_q;
  logic [CNT_W-1:0] cycles_q;
  logic             busy_q;
  logic             done_q;
  logic             start_ok;
  logic             tick;
  logic             last_pulse;

  assign start_ok   = (state == ST_IDLE) && bus.start && !bus.halt_req && (bus.mode != MODE_HALT);
  // The pulse now on the wire is the last of the budget once it gets counted.
  assign last_pulse = cpu_en_q && (cycles_q == run_len_q - CNT_W'(1));

  clk_en_div #(.DIV_W(DIV_W)) u_div (
    .clk   (sysclk),
    .rst_n (sysrst_n),
    .clr   (start_ok),
    .en    (state == ST_RUN),
    .div   (div_q),
    .tick  (tick)
  );

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      count_mode <= 1'b0;
      run_len_q  <= '0;
      div_q      <= '0;
      cpu_rst_q  <= 1'b0;
      cpu_en_q   <= 1'b0;
      cycles_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      cpu_en_q <= 1'b0;
      if (cpu_en_q && (cycles_q != '1)) begin
        cycles_q <= cycles_q + CNT_W'(1);
      end
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            cpu_rst_q <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_IDLE: begin
          if (start_ok) begin
            cycles_q   <= '0;
            run_len_q  <= bus.run_len;
            div_q      <= bus.div;
            count_mode <= (bus.mode == MODE_COUNT);
            case (bus.mode)
              MODE_FREE: begin
                state  <= ST_RUN;
                busy_q <= 1'b1;
              end
              MODE_COUNT: begin
                if (bus.run_len == '0) begin
                  done_q <= 1'b1;
                end else begin
                  state  <= ST_RUN;
                  busy_q <= 1'b1;
                end
              end
              MODE_STEP: begin
                state  <= ST_STEP;
                busy_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (bus.halt_req) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (count_mode && last_pulse) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cpu_en_q <= tick;
          end
        end
        ST_STEP: begin
          if (bus.halt_req) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cpu_en_q <= bus.step;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  assign bus.cpu_rst_n = cpu_rst_q;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.cycles    = cycles_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
// tb/tb_cpu_cycle_ctrl.sv - self-checking bench for cpu_cycle_ctrl with a per-edge expectation model
module tb_cpu_cycle_ctrl;
  import cpu_cycle_pkg::*;

  localparam int CNT_W    = 16;
  localparam int DIV_W    = 8;
  localparam int RST_HOLD = 4;
  localparam int MAXE     = 70000;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cpu_cycle_ctrl_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  cpu_cycle_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD)) dut (
    .sysclk   (clk),
    .sysrst_n (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected output values just after edge number e.
  bit e_en   [MAXE];
  bit e_busy [MAXE];
  bit e_done [MAXE];
  bit e_clr  [MAXE];

  int ec          = 0;
  int vectors     = 0;
  int miscompares = 0;
  int mcyc        = 0;
  int rel_edge    = 0;
  bit in_reset    = 1'b1;
  bit step_run    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, ec);
    end
  endtask

  function automatic void clear_from(input int e0);
    for (int e = e0; e < MAXE; e++) begin
      e_en[e] = 1'b0;
      e_busy[e] = 1'b0;
      e_done[e] = 1'b0;
      e_clr[e] = 1'b0;
    end
  endfunction

  // Pulse k of a run started at edge s lands at s + k*(div+1); a count run ends one edge after its last pulse.
  function automatic void plan(input int s, input logic [1:0] m, input int rl, input int dv);
    int fin;
    e_clr[s] = 1'b1;
    step_run = (m == MODE_STEP);
    if (m == MODE_COUNT && rl == 0) begin
      e_done[s] = 1'b1;
    end else if (m == MODE_STEP) begin
      for (int e = s; e < MAXE; e++) e_busy[e] = 1'b1;
    end else begin
      for (int k = 1; s + k * (dv + 1) < MAXE; k++) begin
        if (m == MODE_COUNT && k > rl) break;
        e_en[s + k * (dv + 1)] = 1'b1;
      end
      fin = (m == MODE_COUNT) ? s + rl * (dv + 1) + 1 : MAXE;
      for (int e = s; e < fin && e < MAXE; e++) e_busy[e] = 1'b1;
      if (fin < MAXE) e_done[fin] = 1'b1;
    end
  endfunction

  task automatic step_clk();
    logic exp_rstn;
    @(posedge clk);
    ec++;
    if (in_reset || e_clr[ec]) mcyc = 0;
    else if (e_en[ec-1] && mcyc < CMAX) mcyc++;
    #1;
    exp_rstn = !in_reset && (ec >= rel_edge + RST_HOLD);
    chk("cpu_rst_n", bus.cpu_rst_n, 32'(exp_rstn));
    chk("cpu_en", bus.cpu_en, 32'(e_en[ec]));
    chk("busy", bus.busy, 32'(e_busy[ec]));
    chk("done", bus.done, 32'(e_done[ec]));
    chk("cycles", bus.cycles, mcyc);
  endtask

  task automatic run_cycles(input int n, input bit rnd_step);
    for (int i = 0; i < n; i++) begin
      bus.step = rnd_step ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.step && e_busy[ec] && step_run) e_en[ec+1] = 1'b1;
      step_clk();
    end
    bus.step = 1'b0;
  endtask

  task automatic do_steps(input int n);
    bus.step = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (e_busy[ec] && step_run) e_en[ec+1] = 1'b1;
      step_clk();
    end
    bus.step = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input int rl, input int dv, input bit with_halt);
    bit ok;
    bus.mode     = m;
    bus.run_len  = CNT_W'(rl);
    bus.div      = DIV_W'(dv);
    bus.start    = 1'b1;
    bus.halt_req = with_halt;
    ok = !in_reset && (ec >= rel_edge + RST_HOLD) && !e_busy[ec] && !with_halt && (m != MODE_HALT);
    if (ok) plan(ec + 1, m, rl, dv);
    step_clk();
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  task automatic do_halt();
    bus.halt_req = 1'b1;
    clear_from(ec + 1);
    step_clk();
    bus.halt_req = 1'b0;
  endtask

  initial begin
    int kind, dv, rl;
    bus.mode = MODE_HALT; bus.start = 1'b0; bus.step = 1'b0; bus.halt_req = 1'b0;
    bus.run_len = '0; bus.div = '0;

    // reset release and hold period
    run_cycles(3, 0);
    @(negedge clk); rst_n = 1'b1; in_reset = 1'b0; rel_edge = ec;
    run_cycles(6, 1);

    // free run, div 0, ten pulses then halt
    do_start(MODE_FREE, 0, 0, 0);
    run_cycles(10, 0);
    do_halt();
    chk("t2_cycles", bus.cycles, 10);
    chk("t2_busy", bus.busy, 0);
    run_cycles(2, 0);

    // count run, 5 pulses every third cycle
    do_start(MODE_COUNT, 5, 2, 0);
    run_cycles(20, 0);
    chk("t3_cycles", bus.cycles, 5);
    chk("t3_busy", bus.busy, 0);

    // step mode: spaced steps then a back-to-back pair
    do_start(MODE_STEP, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_cycles(3, 0);
      do_steps(1);
    end
    run_cycles(3, 0);
    do_steps(2);
    run_cycles(2, 0);
    chk("t4_cycles", bus.cycles, 5);
    do_halt();
    run_cycles(2, 0);

    // edge cases
    do_start(MODE_COUNT, 0, 0, 0);
    run_cycles(3, 0);
    do_start(MODE_FREE, 0, 0, 1);
    run_cycles(3, 0);
    chk("t5_halt_start_busy", bus.busy, 0);
    do_start(MODE_COUNT, 6, 1, 0);
    run_cycles(5, 0);
    do_start(MODE_FREE, 0, 0, 0);
    run_cycles(12, 0);
    chk("t5_busy_start_cycles", bus.cycles, 6);

    // asynchronous reset in the middle of a count run
    do_start(MODE_COUNT, 10, 0, 0);
    run_cycles(4, 0);
    chk("t6_cycles_pre", bus.cycles, 3);
    #3;
    rst_n = 1'b0; in_reset = 1'b1; mcyc = 0; clear_from(ec + 1);
    #1;
    chk("t6_async_rstn", bus.cpu_rst_n, 0);
    chk("t6_async_en", bus.cpu_en, 0);
    chk("t6_async_cycles", bus.cycles, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_done", bus.done, 0);
    run_cycles(3, 0);
    @(negedge clk); rst_n = 1'b1; in_reset = 1'b0; rel_edge = ec;
    run_cycles(6, 0);
    do_start(MODE_COUNT, 3, 1, 0);
    run_cycles(10, 0);
    chk("t6_cycles_post", bus.cycles, 3);

    // randomized runs
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      dv   = $urandom_range(0, 3);
      rl   = $urandom_range(0, 6);
      case (kind)
        0: begin
          do_start(MODE_FREE, rl, dv, 0);
          run_cycles($urandom_range(2, 20), 1);
          do_halt();
        end
        1: begin
          do_start(MODE_COUNT, rl, dv, 0);
          run_cycles($urandom_range(0, (rl + 1) * (dv + 1) + 2), 1);
          if ($urandom_range(0, 1) == 1) do_halt();
          run_cycles((rl + 1) * (dv + 1) + 2, 0);
        end
        2: begin
          do_start(MODE_STEP, rl, dv, 0);
          run_cycles($urandom_range(3, 15), 1);
          do_halt();
        end
        default: begin
          do_start(2'($urandom_range(0, 3)), rl, dv, 1'($urandom_range(0, 1)));
          run_cycles(3, 1);
          do_halt();
        end
      endcase
      run_cycles($urandom_range(1, 4), 0);
    end

    // saturation of the retired-cycle counter
    do_start(MODE_FREE, 0, 0, 0);
    run_cycles(65538, 0);
    chk("sat_cycles", bus.cycles, CMAX);
    do_halt();
    run_cycles(2, 0);
    chk("sat_hold", bus.cycles, CMAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
